// File: rtl/tb_bank_sched.sv
// Two-bank survivor-path scheduler: fills banks from ACS words and issues tracebacks to the TBU.
// Optional macro TB_FLUSH_EN lets di_flush close a partly filled bank early.
module tb_bank_sched #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          di_sur_path_vld,
  input  logic [5:0]    di_cur_state,
  input  logic          di_cur_state_vld,
  input  logic          di_flush,
  input  logic          tb_done,
  output logic          wr_en,
  output logic [AW:0]   wr_addr,
  output logic          tb_start,
  output logic          tb_bank,
  output logic [5:0]    tb_state,
  output logic [AW:0]   tb_len,
  output logic          busy,
  output logic          err_ovf
);

  // state    | meaning
  // EMPTY    | bank free, may accept words
  // FILLING  | bank is the write target and holds 1..DEPTH-1 words
  // FULL     | bank closed, waiting for its start state and/or the TBU
  // TRACING  | TBU is tracing this bank
  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_TRACING} bank_st_e;

  bank_st_e        r_status [2];
  bank_st_e        w_status [2];
  logic [1:0]      r_cap, w_cap;
  logic [5:0]      r_state [2];
  logic [5:0]      w_state [2];
  logic            r_wbank, w_wbank;
  logic [AW-1:0]   r_wcnt, w_wcnt;
  logic            r_age, w_age;
  logic            r_wr_en, w_wr_en;
  logic [AW:0]     r_wr_addr, w_wr_addr;
  logic            r_tb_start, w_tb_start;
  logic            r_tb_bank, w_tb_bank;
  logic [5:0]      r_tb_state, w_tb_state;
  logic [AW:0]     r_tb_len, w_tb_len;
  logic            r_busy, w_busy;
  logic            r_ovf, w_ovf;
  logic            w_tracing, w_complete, w_sel_cap, w_sel_iss;
  logic [1:0]      w_capmask, w_issmask;
  logic [AW:0]     w_fill_len;
`ifdef TB_FLUSH_EN
  logic [AW:0]     r_len [2];
  logic [AW:0]     w_len [2];
`endif

  always_comb begin
    w_status   = r_status;
    w_cap      = r_cap;
    w_state    = r_state;
    w_wbank    = r_wbank;
    w_wcnt     = r_wcnt;
    w_age      = r_age;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_wr_addr;
    w_tb_start = 1'b0;
    w_tb_bank  = r_tb_bank;
    w_tb_state = r_tb_state;
    w_tb_len   = r_tb_len;
    w_ovf      = r_ovf;
    w_complete = 1'b0;
    w_fill_len = (AW+1)'(DEPTH);
    w_sel_cap  = 1'b0;
    w_sel_iss  = 1'b0;
`ifdef TB_FLUSH_EN
    w_len      = r_len;
`endif
    w_tracing  = (r_status[0] == ST_TRACING) || (r_status[1] == ST_TRACING);

    // Release first so a bank freed this cycle can take the next word.
    if (tb_done) begin
      for (int b = 0; b < 2; b++) begin
        if (r_status[b] == ST_TRACING) begin
          w_status[b] = ST_EMPTY;
          w_cap[b]    = 1'b0;
        end
      end
    end

    if (di_sur_path_vld) begin
      if (w_status[r_wbank] == ST_EMPTY || w_status[r_wbank] == ST_FILLING) begin
        w_wr_en            = 1'b1;
        w_wr_addr          = {r_wbank, r_wcnt};
        w_status[r_wbank]  = ST_FILLING;
        w_wcnt             = r_wcnt + AW'(1);
        if (r_wcnt == AW'(DEPTH-1)) w_complete = 1'b1;
      end else begin
        w_ovf = 1'b1;
      end
    end

`ifdef TB_FLUSH_EN
    if (di_flush && !w_complete && w_status[r_wbank] == ST_FILLING) begin
      w_complete = 1'b1;
      w_fill_len = {1'b0, w_wcnt};
    end
`endif

    if (w_complete) begin
      w_status[r_wbank] = ST_FULL;
`ifdef TB_FLUSH_EN
      w_len[r_wbank]    = w_fill_len;
`endif
      w_wcnt            = '0;
      w_wbank           = ~r_wbank;
      w_age             = (w_status[~r_wbank] == ST_FULL) ? ~r_wbank : r_wbank;
    end

    w_capmask[0] = (r_status[0] == ST_FULL) && !r_cap[0];
    w_capmask[1] = (r_status[1] == ST_FULL) && !r_cap[1];
    if (di_cur_state_vld && (w_capmask != 2'b00)) begin
      w_sel_cap          = (w_capmask == 2'b11) ? r_age : w_capmask[1];
      w_cap[w_sel_cap]   = 1'b1;
      w_state[w_sel_cap] = di_cur_state;
    end

    // Issue looks at the registered TRACING status, which forces the idle cycle after tb_done.
    w_issmask[0] = (r_status[0] == ST_FULL) && w_cap[0];
    w_issmask[1] = (r_status[1] == ST_FULL) && w_cap[1];
    if (!w_tracing && (w_issmask != 2'b00)) begin
      w_sel_iss           = (w_issmask == 2'b11) ? r_age : w_issmask[1];
      w_status[w_sel_iss] = ST_TRACING;
      w_tb_start          = 1'b1;
      w_tb_bank           = w_sel_iss;
      w_tb_state          = w_state[w_sel_iss];
`ifdef TB_FLUSH_EN
      w_tb_len            = w_len[w_sel_iss];
`else
      w_tb_len            = (AW+1)'(DEPTH);
`endif
    end

    w_busy = (w_status[0] != ST_EMPTY) || (w_status[1] != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_status   <= '{ST_EMPTY, ST_EMPTY};
      r_cap      <= '0;
      r_state    <= '{6'd0, 6'd0};
      r_wbank    <= 1'b0;
      r_wcnt     <= '0;
      r_age      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_tb_start <= 1'b0;
      r_tb_bank  <= 1'b0;
      r_tb_state <= '0;
      r_tb_len   <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef TB_FLUSH_EN
      r_len      <= '{'0, '0};
`endif
    end else begin
      r_status   <= w_status;
      r_cap      <= w_cap;
      r_state    <= w_state;
      r_wbank    <= w_wbank;
      r_wcnt     <= w_wcnt;
      r_age      <= w_age;
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      r_tb_start <= w_tb_start;
      r_tb_bank  <= w_tb_bank;
      r_tb_state <= w_tb_state;
      r_tb_len   <= w_tb_len;
      r_busy     <= w_busy;
      r_ovf      <= w_ovf;
`ifdef TB_FLUSH_EN
      r_len      <= w_len;
`endif
    end
  end

  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign tb_start = r_tb_start;
  assign tb_bank  = r_tb_bank;
  assign tb_state = r_tb_state;
  assign tb_len   = r_tb_len;
  assign busy     = r_busy;
  assign err_ovf  = r_ovf;

endmodule

// File: doc/tb_bank_sched.md
TB_BANK_SCHED -- requirements
Module: tb_bank_sched

Interface — parameters
REQ-001 DEPTH, default 32: survivor-path words per bank (traceback depth); power of two, 4..64.
REQ-002 AW, default 5: log2(DEPTH).

Interface — ports
REQ-003 clk  in  1  working clock; all logic is rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 di_sur_path_vld  in  1  ACS survivor word valid; one word per asserted cycle.
REQ-006 di_cur_state  in  6  traceback start state from SDS.
REQ-007 di_cur_state_vld  in  1  di_cur_state valid, single-cycle pulse.
REQ-008 di_flush  in  1  end-of-frame pulse.
REQ-009 tb_done  in  1  TBU finished the issued traceback, single-cycle pulse.
REQ-010 wr_en  out  1  survivor RAM write enable.
REQ-011 wr_addr  out  AW+1  RAM write address {bank, offset}.
REQ-012 tb_start  out  1  traceback launch, single-cycle pulse.
REQ-013 tb_bank  out  1  bank to trace; held from tb_start to tb_done.
REQ-014 tb_state  out  6  start state for the trace; held from tb_start to tb_done.
REQ-015 tb_len  out  AW+1  valid words in the traced bank (1..DEPTH).
REQ-016 busy  out  1  high while any bank is not EMPTY.
REQ-017 err_ovf  out  1  sticky overflow flag.

Function
REQ-018 Each of the two banks shall hold one status: EMPTY, FILLING, FULL or TRACING; at most one bank is FILLING and at most one is TRACING.
REQ-019 On di_sur_path_vld with the write bank EMPTY or FILLING: the next cycle asserts wr_en with wr_addr={wbank,wcnt}, wcnt increments, and the bank becomes FILLING (1-cycle write latency).
REQ-020 The write of offset DEPTH-1 shall mark the bank FULL with len=DEPTH, reset wcnt to 0 and toggle wbank.
REQ-021 If the new wbank is not EMPTY, incoming words shall be dropped (wr_en low) and err_ovf set until that bank becomes EMPTY.
REQ-022 A tb_done in the same cycle as the completing write shall free the bank before the switch decision, so no overflow results.
REQ-023 di_cur_state_vld shall be latched into the oldest FULL bank that has no state captured.
REQ-024 di_cur_state_vld with no such bank shall be ignored.
REQ-025 When no bank is TRACING and a FULL bank has its state captured, tb_start shall pulse the next cycle with tb_bank, tb_state and tb_len of that bank, and the bank becomes TRACING.
REQ-026 If both banks qualify, the older-filled bank goes first (age bit).
REQ-027 On tb_done the TRACING bank shall become EMPTY and its captured-state flag shall clear.
REQ-028 tb_done with no TRACING bank shall be ignored.
REQ-029 Issue shall be re-evaluated the cycle after tb_done, giving one idle cycle minimum between traces.
REQ-030 busy = OR over both banks of (status != EMPTY), registered.

Reset
REQ-031 On rst low at a clk edge: both banks EMPTY, wbank=0, wcnt=0, age=0, state flags cleared.
REQ-032 On the same edge, all outputs go to 0: wr_en, wr_addr, tb_start, tb_bank, tb_state, tb_len, busy, err_ovf.
REQ-033 Reset asserted mid-trace shall abandon the trace; a later tb_done is ignored per REQ-028.

Configuration
REQ-034 Macro TB_FLUSH_EN defined: di_flush with the write bank FILLING (wcnt>0) shall mark it FULL with len=wcnt, toggle wbank and clear wcnt.
REQ-035 Under TB_FLUSH_EN, di_flush with wcnt=0 shall have no effect.
REQ-036 Under TB_FLUSH_EN, di_flush and di_sur_path_vld in the same cycle shall write the word first and include it in len.
REQ-037 Macro TB_FLUSH_EN undefined: di_flush shall be ignored and tb_len shall be constant DEPTH.

Verification
REQ-038 After reset, 32 consecutive valid words, then state 6'd17 -> wr_addr 0..31 then bank 1; tb_start, tb_bank=0, tb_state=17, tb_len=32 one cycle after the state pulse.
REQ-039 64 words with tb_done withheld, then 1 more word -> word 65 dropped, err_ovf=1, wr_en low.
REQ-040 Both banks FULL with states captured (bank1 filled first) -> first tb_start has tb_bank=1; second has tb_bank=0, issued 2 cycles after tb_done.
REQ-041 tb_done coincident with a bank's 32nd write -> no err_ovf; the next word goes to offset 0 of the freed bank.
REQ-042 TB_FLUSH_EN, 10 words then di_flush plus state 6'd5 -> tb_len=10, tb_state=5; without the macro, no tb_start occurs.
REQ-043 rst low mid-trace -> all outputs 0 next cycle; a later tb_done causes no change.
